// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by the APB initiator and by the slave-side register blocks.
package apb_pkg;

  localparam int unsigned APB_ADDR_W         = 8;
  localparam int unsigned APB_DATA_W         = 8;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_8bit_if.sv
// Bundle of the command/response side and the APB side of apb_master_8bit.
//  cmd_*  : single-beat command from local control logic (valid/ready)
//  rsp_*  : one-cycle response strobe with read data and error
//  p*     : APB bus toward register slaves
// Modports: master = initiator view, slave = view of everything around it.
interface apb_master_8bit_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait timer: counts consecutive pready=0 cycles and flags the
// cycle on which the LIMIT-th wait cycle occurs. Only present when
// APB_TIMEOUT_EN is defined.
//  clk, rst_n : clock, async active-low reset
//  clr        : clear count (asserted while entering ACCESS)
//  run        : ACCESS with pready low
//  expired_c  : combinational, high on the LIMIT-th consecutive wait cycle
`ifdef APB_TIMEOUT_EN
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Wait-cycle counter; saturates at the expiry point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = run && (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/apb_master_8bit.sv
// APB initiator: turns single-beat commands into APB SETUP/ACCESS transfers
// and returns read data / error on a one-cycle response strobe.
//  clk, rst_n : clock (rising edge), async active-low reset
//  bus        : apb_master_8bit_if.master (cmd_*, rsp_*, APB p* signals)
// All outputs are registered. Optional feature macro: APB_TIMEOUT_EN adds an
// ACCESS wait limit of TIMEOUT_CYCLES; without it ACCESS waits on pready.
module apb_master_8bit
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  apb_master_8bit_if.master   bus
);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              wait_expired_c;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == APB_SETUP),
    .run      ((state_q == APB_ACCESS) && !bus.pready),
    .expired_c(wait_expired_c)
  );
`else
  assign wait_expired_c = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= APB_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state and next registered outputs.
  // cmd_ready is the registered "next state is IDLE", so the accept test uses
  // cmd_ready_q to match exactly what the requester sees.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      APB_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = APB_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
        end
      end
      APB_SETUP: begin
        state_d   = APB_ACCESS;
        penable_d = 1'b1;
      end
      APB_ACCESS: begin
        if (bus.pready || wait_expired_c) begin
          state_d     = APB_IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (bus.pready) begin
            rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
            rsp_err_d   = bus.pslverr;
          end else begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d   = APB_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_8bit.sv
// Self-checking bench for apb_master_8bit with a behavioural register slave
// and a response scoreboard. Honours APB_TIMEOUT_EN for the wait-limit step.
module tb_apb_master_8bit;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;

  apb_master_8bit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_8bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: register bank plus programmable wait states / error.
  logic [7:0] mem [256];
  int         wait_n;
  bit         hang;
  bit         err_flag;
  bit         force_en;
  logic [7:0] force_val;
  int         acc_cnt;

  assign bus.pready  = bus.psel && bus.penable && !hang && (acc_cnt >= wait_n);
  assign bus.prdata  = force_en ? force_val : mem[bus.paddr];
  assign bus.pslverr = err_flag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 0;
    end else begin
      if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (bus.psel && bus.penable && bus.pready && bus.pwrite) mem[bus.paddr] <= bus.pwdata;
    end
  end

  // Scoreboard and counters.
  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  int   n_rsp;
  int   n_exp_rsp;

  always @(negedge clk) if (bus.rsp_valid === 1'b1) n_rsp++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One complete transfer: accept, SETUP, ACCESS (counted), response.
  task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int exp_acc, input logic [7:0] exp_rd, input logic exp_err,
                         input bit poke);
    bit   got;
    bit   unstable;
    int   acc;
    exp_t e;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.cmd_ready === 1'b1) got = 1;
      else @(negedge clk);
    end
    check("cmd_ready_before_cmd", 32'(got), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    exp_q.push_back('{rdata: (wr ? 8'h00 : exp_rd), err: exp_err});
    n_exp_rsp++;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("setup_psel_penable_ready", {29'd0, bus.psel, bus.penable, bus.cmd_ready}, 32'b100);
    check("setup_addr_dir", {23'd0, bus.pwrite, bus.paddr}, {23'd0, wr, addr});
    if (wr) check("setup_pwdata", 32'(bus.pwdata), 32'(wdata));
    @(negedge clk);
    got = 0;
    unstable = 0;
    acc = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1;
      end else begin
        if (bus.psel === 1'b1 && bus.penable === 1'b1) acc++;
        if (bus.paddr !== addr || bus.pwrite !== wr || (wr && bus.pwdata !== wdata)) unstable = 1;
        if (poke) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_addr  = 8'hFF;
          bus.cmd_write = ~wr;
        end
        @(negedge clk);
      end
    end
    bus.cmd_valid = 1'b0;
    check("rsp_seen", 32'(got), 32'd1);
    if (got && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
      check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      check("end_psel_penable_ready", {29'd0, bus.psel, bus.penable, bus.cmd_ready}, 32'b001);
      check("access_cycles", 32'(acc), 32'(exp_acc));
      check("access_stable", 32'(unstable), 32'd0);
    end
    @(negedge clk);
    check("rsp_one_cycle_idle_gap", {30'd0, bus.rsp_valid, bus.psel}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    n_pass = 0; n_total = 0; n_exp_rsp = 0;
    wait_n = 0; hang = 0; err_flag = 0; force_en = 0; force_val = 8'h00;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00;

    // Reset: every output low while rst_n is low, cmd_ready one edge after release.
    rst_n = 1'b0;
    #1;
    check("reset_ctrl_outputs",
          {26'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable, bus.pwrite}, 32'd0);
    check("reset_data_outputs", {8'd0, bus.paddr, bus.pwdata, bus.rsp_rdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("cmd_ready_low_at_release", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_after_release", 32'(bus.cmd_ready), 32'd1);

    // Zero-wait write.
    do_xfer(1'b1, 8'h10, 8'hA5, 1, 8'h00, 1'b0, 1'b0);
    check("slave_reg_10", 32'(mem[8'h10]), 32'hA5);

    // Read with three wait states; a busy-time command must be ignored.
    wait_n = 3; force_en = 1; force_val = 8'h5A;
    do_xfer(1'b0, 8'h10, 8'h00, 4, 8'h5A, 1'b0, 1'b1);
    force_en = 0; wait_n = 0;
    check("rsp_rdata_held", 32'(bus.rsp_rdata), 32'h5A);

    // Slave error on a write, then a clean read clears rsp_err.
    err_flag = 1;
    do_xfer(1'b1, 8'h20, 8'h33, 1, 8'h00, 1'b1, 1'b0);
    check("rsp_err_held", 32'(bus.rsp_err), 32'd1);
    err_flag = 0; wait_n = 1;
    do_xfer(1'b0, 8'h20, 8'h00, 2, 8'h33, 1'b0, 1'b0);
    wait_n = 0;

    // Reset during ACCESS abandons the transfer.
    hang = 1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h10; bus.cmd_wdata = 8'h77;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_reset_in_access", {30'd0, bus.psel, bus.penable}, 32'b11);
    rst_n = 1'b0;
    #1;
    check("mid_reset_drop", {28'd0, bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("mid_reset_slave_unchanged", 32'(mem[8'h10]), 32'hA5);
    hang = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // Slave never ready.
    hang = 1;
`ifdef APB_TIMEOUT_EN
    do_xfer(1'b0, 8'h10, 8'h00, 16, 8'h00, 1'b1, 1'b0);
`else
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h10;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    check("no_timeout_no_rsp", 32'(seen), 32'd0);
    check("no_timeout_still_access", {30'd0, bus.psel, bus.penable}, 32'b11);
    hang = 0;
    apply_reset();
`endif
    hang = 0;

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("response_count", 32'(n_rsp), 32'(n_exp_rsp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
